writeback_pipe: RTL and testbench

Parametrised writeback pipeline for the CPU datapath. It generalises the single-stage load forwarding around the control unit to a memory read latency of DEPTH cycles. It adds load-use hazard detection, an external stall and a synchronous flush. It sits between the control unit and the register file write port: it delays memory-read writebacks until data returns and passes all other writebacks straight through.

---
 rtl/writeback_pipe.sv | 142 ++++++++++++++
 tb/tb_writeback_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_pipe.sv
// writeback_pipe: delays memory-read writebacks by DEPTH cycles, passes other
// writebacks straight through, and raises hold on load-use or write-port collision.
module writeback_pipe #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 4,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_en,
  input  logic              id_en2,
  input  logic              id_memread,
  input  logic              id_ret,
  input  logic [SEL_W-1:0]  id_sel,
  input  logic [ADDR_W-1:0] id_rs1,
  input  logic [ADDR_W-1:0] id_rs2,
  output logic [ADDR_W-1:0] wb_dest,
  output logic              wb_en,
  output logic              wb_en2,
  output logic [SEL_W-1:0]  wb_sel,
  output logic              ret_p,
  output logic              hold,
  output logic [2:0]        inflight
);

  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_en;
  logic [DEPTH-1:0]  r_en2;
  logic [ADDR_W-1:0] r_dest [DEPTH];
  logic [SEL_W-1:0]  r_sel  [DEPTH];
  logic              r_ret_p;

  logic [DEPTH-1:0]  w_valid_next;
  logic [DEPTH-1:0]  w_en_next;
  logic [DEPTH-1:0]  w_en2_next;
  logic [ADDR_W-1:0] w_dest_next [DEPTH];
  logic [SEL_W-1:0]  w_sel_next  [DEPTH];

  logic [DEPTH-1:0]  w_match;
  logic              w_head_valid;
  logic              w_load_use;
  logic              w_collision;
  logic              w_hold;
  logic              w_accept;
  logic [2:0]        w_count;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Stages with both enables low (store-to-pc path) never block a reader.
      assign w_match[gi] = r_valid[gi] & (r_en[gi] | r_en2[gi]) &
                           ((r_dest[gi] == id_rs1) | (r_dest[gi] == id_rs2));
      if (gi == 0) begin : g_entry
        assign w_valid_next[gi] = w_accept;
        assign w_en_next[gi]    = id_en;
        assign w_en2_next[gi]   = id_en2;
        assign w_dest_next[gi]  = id_dest;
        assign w_sel_next[gi]   = id_sel;
      end else begin : g_shift
        assign w_valid_next[gi] = r_valid[gi-1];
        assign w_en_next[gi]    = r_en[gi-1];
        assign w_en2_next[gi]   = r_en2[gi-1];
        assign w_dest_next[gi]  = r_dest[gi-1];
        assign w_sel_next[gi]   = r_sel[gi-1];
      end
    end
  endgenerate

  assign w_head_valid = r_valid[DEPTH-1];
  assign w_load_use   = |w_match;
  // The head owns the write port this cycle, so a non-load writer must replay.
  assign w_collision  = w_head_valid & (id_en | id_en2) & ~id_memread;
  assign w_hold       = ~stall & (w_load_use | w_collision);
  assign w_accept     = id_memread & ~w_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_en    <= '0;
      r_en2   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dest[i] <= '0;
        r_sel[i]  <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else if (!stall) begin
      r_valid <= w_valid_next;
      r_en    <= w_en_next;
      r_en2   <= w_en2_next;
      for (int i = 0; i < DEPTH; i++) begin
        r_dest[i] <= w_dest_next[i];
        r_sel[i]  <= w_sel_next[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ret_p <= 1'b0;
    end else if (flush) begin
      r_ret_p <= 1'b0;
    end else if (!stall) begin
      r_ret_p <= w_hold ? 1'b0 : id_ret;
    end
  end

  always_comb begin
    wb_dest = id_dest;
    wb_en   = 1'b0;
    wb_en2  = 1'b0;
    wb_sel  = '0;
    if (stall) begin
      wb_dest = id_dest;
    end else if (w_head_valid) begin
      wb_dest = r_dest[DEPTH-1];
      wb_en   = r_en[DEPTH-1];
      wb_en2  = r_en2[DEPTH-1];
      wb_sel  = r_sel[DEPTH-1];
    end else if (id_memread || w_hold) begin
      wb_dest = id_dest;
    end else begin
      wb_en  = id_en;
      wb_en2 = id_en2;
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + 3'(r_valid[i]);
    end
  end

  assign hold     = w_hold;
  assign ret_p    = r_ret_p;
  assign inflight = w_count;

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe: four instances (DEPTH=1..4) share stimulus;
// each scenario checks the instance it targets against hand-computed values.
module tb_writeback_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] id_dest = '0;
  logic       id_en = 1'b0;
  logic       id_en2 = 1'b0;
  logic       id_memread = 1'b0;
  logic       id_ret = 1'b0;
  logic [2:0] id_sel = '0;
  logic [3:0] id_rs1 = '0;
  logic [3:0] id_rs2 = '0;

  logic [3:0] wb_dest  [4];
  logic [3:0] wb_en;
  logic [3:0] wb_en2;
  logic [2:0] wb_sel   [4];
  logic [3:0] ret_p;
  logic [3:0] hold;
  logic [2:0] inflight [4];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      writeback_pipe #(.DEPTH(gi + 1), .ADDR_W(4), .SEL_W(3)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .flush     (flush),
        .id_dest   (id_dest),
        .id_en     (id_en),
        .id_en2    (id_en2),
        .id_memread(id_memread),
        .id_ret    (id_ret),
        .id_sel    (id_sel),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .wb_dest   (wb_dest[gi]),
        .wb_en     (wb_en[gi]),
        .wb_en2    (wb_en2[gi]),
        .wb_sel    (wb_sel[gi]),
        .ret_p     (ret_p[gi]),
        .hold      (hold[gi]),
        .inflight  (inflight[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [3:0] dest, input logic en,
                       input logic en2, input logic [2:0] sel, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic ret);
    id_memread = mr;
    id_dest    = dest;
    id_en      = en;
    id_en2     = en2;
    id_sel     = sel;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_ret     = ret;
    stall      = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state on every depth
    idle();
    id_dest = 4'd9;
    nxt();
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_inflight_d%0d", d + 1), inflight[d], 0);
      chk($sformatf("rst_hold_d%0d", d + 1), hold[d], 0);
      chk($sformatf("rst_wb_en_d%0d", d + 1), wb_en[d], 0);
      chk($sformatf("rst_wb_sel_d%0d", d + 1), wb_sel[d], 0);
      chk($sformatf("rst_wb_dest_d%0d", d + 1), wb_dest[d], 9);
      chk($sformatf("rst_ret_p_d%0d", d + 1), ret_p[d], 0);
    end
    reset = 1'b0;

    // A: DEPTH=2 single load r3 sel=100
    do_reset();
    drive(1'b1, 4'd3, 1'b1, 1'b0, 3'b100, 4'd0, 4'd0, 1'b0); #1;
    chk("A_c0_wb_en", wb_en[1], 0);
    chk("A_c0_wb_dest", wb_dest[1], 3);
    chk("A_c0_hold", hold[1], 0);
    nxt(); idle(); #1;
    chk("A_c1_inflight", inflight[1], 1);
    chk("A_c1_wb_en", wb_en[1], 0);
    nxt(); idle(); #1;
    chk("A_c2_wb_en", wb_en[1], 1);
    chk("A_c2_wb_dest", wb_dest[1], 3);
    chk("A_c2_wb_sel", wb_sel[1], 3'b100);
    chk("A_c2_inflight", inflight[1], 1);
    nxt(); idle(); #1;
    chk("A_c3_wb_en", wb_en[1], 0);
    chk("A_c3_wb_sel", wb_sel[1], 0);
    chk("A_c3_inflight", inflight[1], 0);

    // B: DEPTH=2 load r5 then dependent ALU op (with id_ret) reading r5
    do_reset();
    drive(1'b1, 4'd5, 1'b1, 1'b0, 3'd1, 4'd0, 4'd0, 1'b0); #1;
    nxt();
    drive(1'b0, 4'd6, 1'b1, 1'b0, 3'd0, 4'd5, 4'd0, 1'b1); #1;
    chk("B_c1_hold", hold[1], 1);
    chk("B_c1_wb_en", wb_en[1], 0);
    nxt(); #1;
    chk("B_c2_hold", hold[1], 1);
    chk("B_c2_ret_p", ret_p[1], 0);
    chk("B_c2_wb_en", wb_en[1], 1);
    chk("B_c2_wb_dest", wb_dest[1], 5);
    nxt(); #1;
    chk("B_c3_hold", hold[1], 0);
    chk("B_c3_wb_en", wb_en[1], 1);
    chk("B_c3_wb_dest", wb_dest[1], 6);
    chk("B_c3_ret_p", ret_p[1], 0);
    chk("B_c3_inflight", inflight[1], 0);
    nxt(); idle(); #1;
    chk("B_c4_ret_p", ret_p[1], 1);

    // C: DEPTH=1 load r2 then independent ALU write r7 (both ports)
    do_reset();
    drive(1'b1, 4'd2, 1'b1, 1'b0, 3'd2, 4'd0, 4'd0, 1'b0); #1;
    nxt();
    drive(1'b0, 4'd7, 1'b1, 1'b1, 3'd0, 4'd1, 4'd1, 1'b0); #1;
    chk("C_c1_hold", hold[0], 1);
    chk("C_c1_wb_dest", wb_dest[0], 2);
    chk("C_c1_wb_en", wb_en[0], 1);
    chk("C_c1_wb_en2", wb_en2[0], 0);
    chk("C_c1_wb_sel", wb_sel[0], 2);
    nxt(); #1;
    chk("C_c2_hold", hold[0], 0);
    chk("C_c2_wb_dest", wb_dest[0], 7);
    chk("C_c2_wb_en", wb_en[0], 1);
    chk("C_c2_wb_en2", wb_en2[0], 1);
    chk("C_c2_wb_sel", wb_sel[0], 0);

    // D: DEPTH=3 loads r1, r2, r3 with a stall in cycle 2
    do_reset();
    drive(1'b1, 4'd1, 1'b1, 1'b0, 3'd1, 4'd0, 4'd0, 1'b0); #1;
    nxt();
    drive(1'b1, 4'd2, 1'b1, 1'b0, 3'd2, 4'd0, 4'd0, 1'b0); #1;
    chk("D_c1_hold", hold[2], 0);
    chk("D_c1_inflight", inflight[2], 1);
    nxt();
    drive(1'b1, 4'd3, 1'b1, 1'b0, 3'd3, 4'd0, 4'd0, 1'b0);
    stall = 1'b1; #1;
    chk("D_c2_wb_en", wb_en[2], 0);
    chk("D_c2_hold", hold[2], 0);
    chk("D_c2_inflight", inflight[2], 2);
    nxt();
    drive(1'b1, 4'd3, 1'b1, 1'b0, 3'd3, 4'd0, 4'd0, 1'b0); #1;
    chk("D_c3_inflight", inflight[2], 2);
    chk("D_c3_wb_en", wb_en[2], 0);
    for (int c = 4; c <= 6; c++) begin
      nxt(); idle(); #1;
      chk($sformatf("D_c%0d_wb_en", c), wb_en[2], 1);
      chk($sformatf("D_c%0d_wb_dest", c), wb_dest[2], c - 3);
      chk($sformatf("D_c%0d_wb_sel", c), wb_sel[2], c - 3);
      chk($sformatf("D_c%0d_inflight", c), inflight[2], 7 - c);
    end
    nxt(); idle(); #1;
    chk("D_c7_wb_en", wb_en[2], 0);
    chk("D_c7_inflight", inflight[2], 0);

    // E: DEPTH=4 two loads in flight, then flush together with stall
    do_reset();
    drive(1'b1, 4'd4, 1'b1, 1'b0, 3'd4, 4'd0, 4'd0, 1'b0); #1;
    nxt();
    drive(1'b1, 4'd5, 1'b1, 1'b1, 3'd5, 4'd0, 4'd0, 1'b1); #1;
    nxt(); idle(); #1;
    chk("E_c2_inflight", inflight[3], 2);
    chk("E_c2_ret_p", ret_p[3], 1);
    stall = 1'b1;
    flush = 1'b1; #1;
    chk("E_c2_wb_en", wb_en[3], 0);
    nxt(); idle(); #1;
    chk("E_c3_inflight", inflight[3], 0);
    chk("E_c3_ret_p", ret_p[3], 0);
    for (int c = 3; c < 8; c++) begin
      chk($sformatf("E_c%0d_no_wb", c), {wb_en[3], wb_en2[3]}, 0);
      nxt(); idle(); #1;
    end

    // G: load with both enables low never raises load-use hold
    do_reset();
    drive(1'b1, 4'd5, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b0); #1;
    nxt();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 4'd5, 4'd5, 1'b0); #1;
    chk("G_c1_hold", hold[1], 0);
    chk("G_c1_inflight", inflight[1], 1);

    // F: ret_p holds under stall, then async reset mid-cycle clears it at once
    do_reset();
    drive(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1); #1;
    nxt();
    idle();
    stall = 1'b1; #1;
    chk("F_c1_ret_p", ret_p[0], 1);
    nxt();
    drive(1'b1, 4'd8, 1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 1'b1); #1;
    chk("F_c2_ret_p_kept", ret_p[0], 1);
    nxt(); idle(); #1;
    chk("F_c3_ret_p", ret_p[0], 1);
    chk("F_c3_inflight", inflight[3], 1);
    #2;
    reset = 1'b1;
    #1;
    chk("F_async_ret_p", ret_p[0], 0);
    chk("F_async_inflight", inflight[3], 0);
    reset = 1'b0;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
